// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
// ----------------------------------------------------------------------------
// Shares one downstream memory port between the core's instruction-fetch bus
// (ibus) and data bus (dbus). The winning request is captured into local
// registers and presented downstream, unchanged, until mem_data_ok returns.
// The response is then routed back to the bus that owns the transaction.
//
// The dbus normally wins ties because it carries the older instruction. To
// keep fetch moving, at most MAX_D_STREAK dbus grants can be made back to back
// while an ibus request is waiting. After that the ibus is granted.
//
// If the ibus withdraws its request mid-flight (branch redirect), the request
// has already been issued downstream. It therefore completes in DRAIN, and
// its response is discarded.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   i_valid, i_addr               ibus request
//   i_data_ok, i_rdata            ibus response (32-bit lane chosen by addr[2])
//   d_valid, d_addr, d_size,
//   d_strobe, d_wdata             dbus request (strobe 0 = load)
//   d_data_ok, d_rdata            dbus response
//   mem_valid, mem_addr, mem_size,
//   mem_strobe, mem_wdata         downstream request (registered copies)
//   mem_data_ok, mem_rdata        downstream response
// ============================================================================
module mem_bus_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_data_ok,
    output logic [63:0] d_rdata,

    output logic        mem_valid,
    output logic [63:0] mem_addr,
    output logic [2:0]  mem_size,
    output logic [7:0]  mem_strobe,
    output logic [63:0] mem_wdata,
    input  logic        mem_data_ok,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int              SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);

    state_t        state, state_next;
    logic [SW-1:0] streak, streak_next;
    logic          grant_d;
    logic          grant_i;

    // The dbus wins unless the fetch side has already waited out a full
    // streak of data grants.
    assign grant_d = d_valid && !(i_valid && (streak == STREAK_MAX));
    assign grant_i = !grant_d && i_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next  = state;
        streak_next = streak;

        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = BUSY_D;
                    // The streak only counts while a fetch is actually waiting.
                    if (i_valid)
                        streak_next = (streak == STREAK_MAX) ? streak : streak + 1'b1;
                    else
                        streak_next = '0;
                end else if (grant_i) begin
                    state_next  = BUSY_I;
                    streak_next = '0;
                end
            end

            BUSY_I: begin
                // Completion wins over a same-cycle withdrawal: the response
                // is still delivered.
                if (mem_data_ok)
                    state_next = IDLE;
                else if (!i_valid)
                    state_next = DRAIN;
            end

            BUSY_D: begin
                if (mem_data_ok)
                    state_next = IDLE;
                else if (!d_valid)
                    state_next = DRAIN;
            end

            DRAIN: begin
                if (mem_data_ok)
                    state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, streak counter and latched request fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples values from before this clock edge.
        if (reset) begin
            state      <= IDLE;
            streak     <= '0;
            mem_addr   <= '0;
            mem_size   <= '0;
            mem_strobe <= '0;
            mem_wdata  <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;

            if (state == IDLE) begin
                if (grant_d) begin
                    mem_addr   <= d_addr;
                    mem_size   <= d_size;
                    mem_strobe <= d_strobe;
                    mem_wdata  <= d_wdata;
                end else if (grant_i) begin
                    mem_addr   <= i_addr;
                    mem_size   <= 3'd2;
                    mem_strobe <= 8'h00;
                    mem_wdata  <= 64'h0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The request is visible downstream for as long as a transaction is owned
    // or draining. That is one cycle after the grant, and until the cycle after
    // completion.
    assign mem_valid = (state != IDLE);

    // Responses are suppressed while reset is asserted, so an aborted
    // transaction never produces a pulse.
    assign i_data_ok = !reset && (state == BUSY_I) && mem_data_ok;
    assign d_data_ok = !reset && (state == BUSY_D) && mem_data_ok;

    assign i_rdata = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
    assign d_rdata = mem_rdata;

endmodule
